dcache_sram: RTL

- Data-cache frame store sitting directly behind the cache controller's SRAM port: it consumes sramREN/sramWEN/sramaddr/sramstore and produces sramstate/cacheline.
- Holds 2**INDEX_W packed dcache frames and models a fixed multi-cycle access latency.
- Each access is a request/ACCESS handshake; the controller drives the request and waits for ACCESS.

---
 rtl/dcache_sram.sv | 65 ++++++
 1 files changed

// File: rtl/dcache_sram.sv
// dcache_sram: dcache frame store with a fixed multi-cycle request/ACCESS handshake.
module dcache_sram #(
  parameter int INDEX_W = 3,
  parameter int IDX_LSB = 3,
  parameter int FRAME_W = 92,
  parameter int LAT     = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sramREN,
  input  logic               sramWEN,
  input  logic [31:0]        sramaddr,
  input  logic [FRAME_W-1:0] sramstore,
  output logic [1:0]         sramstate,
  output logic [FRAME_W-1:0] cacheline
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic op;
  logic [INDEX_W-1:0] idx, cur_idx;
  logic [FRAME_W-1:0] wdata;
  logic [FRAME_W-1:0] mem [2**INDEX_W];
  logic both, none, unused_addr;
  assign cur_idx = sramaddr[IDX_LSB +: INDEX_W];
  assign both = sramREN & sramWEN;
  assign none = ~(sramREN | sramWEN);
  assign unused_addr = ^sramaddr;
  assign sramstate = state;
  // Both-high wins over an abort while waiting: a protocol error is always reported.
  always_comb begin
    next = IDLE;
    if (state == IDLE)
      next = both ? ERR : none ? IDLE : WAIT;
    else if (state == WAIT)
      next = both ? ERR
           : (none || sramWEN != op || cur_idx != idx) ? IDLE
           : (cnt == 4'(LAT)) ? DONE : WAIT;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      op <= 1'b0;
      idx <= '0;
      wdata <= '0;
      cacheline <= '0;
      for (int i = 0; i < 2**INDEX_W; i++) mem[i] <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next == WAIT) begin
        cnt <= 4'd1;
        op <= sramWEN;
        idx <= cur_idx;
        wdata <= sramstore;
      end else if (state == WAIT && next == WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (next == DONE) begin
        if (op) mem[idx] <= wdata;
        cacheline <= op ? wdata : mem[idx];
      end
    end
  end
endmodule
